pattern_scan_ctrl: RTL and testbench

Byte-stream front end and sequencer for the serial pattern recognizer.
- Accepts bytes over a valid/ready handshake and serializes each byte MSB-first, one bit per clk.
- Matches the bit stream against a programmable pattern of up to PAT_MAX bits, with overlapping matches allowed.
- Counts matches and signals completion after the frame's last byte.
- Sits between a byte-wide producer (UART/FIFO) and status/interrupt logic.

---
 rtl/pattern_scan_ctrl.sv | 98 +++++++++
 tb/tb_pattern_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: byte-stream serializer and overlapping pattern matcher; PATSCAN_FIRST_STOP_EN stops scanning after the first match
module pattern_scan_ctrl #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);
`ifdef PATSCAN_FIRST_STOP_EN
  typedef enum logic [2:0] {IDLE, RECV, SHIFT, DONE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, SHIFT, DONE} state_t;
`endif
  state_t state, nxt;
  logic [PAT_MAX-1:0] pat, hist, mask, win;
  logic [3:0] len, bits_seen, cfg_eff;
  logic [2:0] idx;
  logic [7:0] byte_r;
  logic last_r, b, hit;
  logic [15:0] m16;
  assign cfg_eff = (cfg_len > 4'(PAT_MAX)) ? 4'(PAT_MAX) : cfg_len;
  assign m16 = (16'd1 << len) - 16'd1;
  assign mask = m16[PAT_MAX-1:0];
  assign b = byte_r[idx];
  assign win = {hist[PAT_MAX-2:0], b};
  assign hit = (state == SHIFT) && (len != 4'd0) && ((win & mask) == (pat & mask))
            && (({1'b0, bits_seen} + 5'd1) >= {1'b0, len});
  assign match = hit;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef PATSCAN_FIRST_STOP_EN
  assign in_ready = (state == RECV) || (state == DRAIN);
`else
  assign in_ready = state == RECV;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? RECV : IDLE;
      RECV:  nxt = in_valid ? SHIFT : RECV;
`ifdef PATSCAN_FIRST_STOP_EN
      SHIFT: nxt = hit ? (last_r ? DONE : DRAIN) : (idx == 3'd0) ? (last_r ? DONE : RECV) : SHIFT;
      DRAIN: nxt = (in_valid && in_last) ? DONE : DRAIN;
`else
      SHIFT: nxt = (idx == 3'd0) ? (last_r ? DONE : RECV) : SHIFT;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat <= PAT_MAX'(13);
      len <= 4'd4;
      hist <= '0;
      bits_seen <= '0;
      idx <= '0;
      byte_r <= '0;
      last_r <= 1'b0;
      match_count <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && cfg_we) begin
        pat <= cfg_pattern;
        len <= cfg_eff;
      end
      if (state == IDLE && start) begin
        match_count <= '0;
        hist <= '0;
        bits_seen <= '0;
      end
      if (state == RECV && in_valid) begin
        byte_r <= in_data;
        last_r <= in_last;
        idx <= 3'd7;
      end
      if (state == SHIFT) begin
        hist <= win;
        bits_seen <= (bits_seen == 4'(PAT_MAX)) ? bits_seen : bits_seen + 4'd1;
        idx <= idx - 3'd1;
        if (hit && !(&match_count)) match_count <= match_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed vectors with hand-computed match masks (bit 7 = first shifted bit)
module tb_pattern_scan_ctrl;
  logic clk = 0, reset = 1, cfg_we = 0, start = 0, in_valid = 0, in_last = 0;
  logic [7:0] cfg_pattern = '0, in_data = '0;
  logic [3:0] cfg_len = '0;
  logic in_ready, match, busy, done;
  logic [15:0] match_count;
  logic [7:0] m;
  int w, errors = 0, checks = 0;
  pattern_scan_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .match(match), .match_count(match_count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_frame(input bit we, input logic [7:0] p, input logic [3:0] l);
    @(negedge clk);
    start = 1; cfg_we = we; cfg_pattern = p; cfg_len = l;
    @(posedge clk); #1;
    start = 0; cfg_we = 0;
  endtask
  task automatic accept(input logic [7:0] d, input bit l, output int wc);
    wc = 0;
    @(negedge clk);
    while (!in_ready && wc < 50) begin
      wc++;
      @(negedge clk);
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic send(input logic [7:0] d, input bit l, output logic [7:0] mm, output int wc);
    accept(d, l, wc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mm[7-i] = match;
    end
  endtask
  task automatic finish_frame(input logic [15:0] cnt);
    @(negedge clk);
    check("done", done, 1);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("count", match_count, cnt);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
`ifdef PATSCAN_FIRST_STOP_EN
    start_frame(0, 8'h00, 4'd0);
    send(8'hDD, 0, m, w);
    check("fs_dd_mask", m, 8'h10);
    check("fs_dd_count", match_count, 1);
    check("fs_drain_ready", in_ready, 1);
    accept(8'hFF, 0, w);
    check("fs_ff_wait", w, 0);
    @(negedge clk);
    check("fs_ff_match", match, 0);
    check("fs_ff_ready", in_ready, 1);
    accept(8'h0D, 1, w);
    finish_frame(1);
    start_frame(0, 8'h00, 4'd0);
    send(8'h6D, 1, m, w);
    check("fs_last_mask", m[7:3], 5'b00001);
    check("fs_last_done", done, 0);
    @(negedge clk);
    check("fs_last_idle", busy, 0);
    check("fs_last_count", match_count, 1);
`else
    start_frame(0, 8'h00, 4'd0);
    send(8'hDD, 1, m, w);
    check("t1_mask", m, 8'h11);
    finish_frame(2);
    start_frame(0, 8'h00, 4'd0);
    @(negedge clk);
    check("t2_cleared", match_count, 0);
    send(8'h6D, 1, m, w);
    check("t2_mask", m, 8'h09);
    finish_frame(2);
    start_frame(0, 8'h00, 4'd0);
    send(8'h03, 0, m, w);
    check("t3_b1_mask", m, 8'h00);
    send(8'h40, 1, m, w);
    check("t3_b2_wait", w, 0);
    check("t3_b2_mask", m, 8'h40);
    finish_frame(1);
    start_frame(1, 8'h05, 4'd3);
    send(8'hAA, 1, m, w);
    check("t4_mask", m, 8'h2A);
    finish_frame(3);
    start_frame(0, 8'h00, 4'd0);
    @(negedge clk);
    cfg_we = 1; cfg_pattern = 8'h00; cfg_len = 4'd2;
    send(8'hAA, 1, m, w);
    cfg_we = 0;
    check("t4_busy_cfg_mask", m, 8'h2A);
    finish_frame(3);
    start_frame(0, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_ready", in_ready, 1);
    end
    accept(8'hAA, 1, w);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_shift3_match", match, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_count", match_count, 0);
    start_frame(0, 8'h00, 4'd0);
    send(8'hDD, 1, m, w);
    check("t5_default_pat", m, 8'h11);
    finish_frame(2);
    start_frame(1, 8'hDD, 4'd15);
    send(8'hDD, 0, m, w);
    check("clamp_b1_mask", m, 8'h01);
    send(8'hDD, 1, m, w);
    check("clamp_b2_mask", m, 8'h11);
    finish_frame(3);
    start_frame(1, 8'hFF, 4'd0);
    send(8'hFF, 1, m, w);
    check("len0_mask", m, 8'h00);
    finish_frame(0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
